// File: rtl/cas_tape_pkg.sv
// Shared types and defaults for the cassette tape engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cas_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HIGH,
        ST_LOW,
        ST_EOT
`ifdef CAS_RECORD_EN
        , ST_REC
`endif
    } cas_state_t;

    localparam int CAS_HALF0_DEF      = 23864;
    localparam int CAS_HALF1_DEF      = 11932;
    localparam int CAS_LOAD_INDEX_DEF = 12;

endpackage

// File: rtl/cas_tape_engine_if.sv
// HPS ioctl download bus feeding the tape engine.
// Latency: n/a (wires only).
// Backpressure: none; the downloader never waits on the engine.
interface cas_tape_engine_if;

    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;

    modport master (
        output ioctl_download,
        output ioctl_index,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_data
    );

    modport slave (
        input ioctl_download,
        input ioctl_index,
        input ioctl_wr,
        input ioctl_addr,
        input ioctl_data
    );

endinterface

// File: rtl/cas_tape_ram.sv
// Simple dual-port tape image RAM, one write and one read port, 2^ADDR_W x 8.
// Latency: 1 cycle registered read; rd_dat holds when rd_en is low.
// Backpressure: none; both ports accept every cycle.
module cas_tape_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_dat
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cas_tape_engine.sv
// CAS image capture and FSK playback (bit0 = 2 x HALF0, bit1 = 2 x HALF1, LSB first); record path under CAS_RECORD_EN.
// Latency: 3-cycle inter-byte gap (IDLE, FETCH, WAIT), then 2 half-periods per bit.
// Backpressure: none; motor low freezes the player, load and rewind preempt it on the next edge.
module cas_tape_engine
    import cas_tape_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int LOAD_INDEX = CAS_LOAD_INDEX_DEF,
    parameter int CNT_W      = 16,
    parameter int HALF0      = CAS_HALF0_DEF,
    parameter int HALF1      = CAS_HALF1_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    cas_tape_engine_if.slave  io,
    input  logic              motor,
    input  logic              rewind,
`ifdef CAS_RECORD_EN
    input  logic              rec,
    input  logic              cas_in,
`endif
    output logic              cas_out,
    output logic              playing,
    output logic              eot,
    output logic [ADDR_W-1:0] position,
    output logic [ADDR_W:0]   length
);

    localparam logic [CNT_W-1:0] HALF0_M1 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] HALF1_M1 = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]  POS_ONE  = (ADDR_W+1)'(1);

    function automatic logic [CNT_W-1:0] half_sel(input logic b);
        return b ? HALF1_M1 : HALF0_M1;
    endfunction

    logic              la, la_q, la_rise, io_wr_ok;
    logic [ADDR_W:0]   io_end, len_base, pos_inc;
    cas_state_t        state_q, state_d;
    logic [ADDR_W:0]   pos_q, pos_d, len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        shreg_q, shreg_d, rd_dat;
    logic [2:0]        bit_q, bit_d;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_dat;

    assign la       = io.ioctl_download && (io.ioctl_index == 8'(LOAD_INDEX));
    assign la_rise  = la && !la_q;
    assign io_wr_ok = la && io.ioctl_wr && (io.ioctl_addr[24:ADDR_W] == '0);
    assign io_end   = {1'b0, io.ioctl_addr[ADDR_W-1:0]} + POS_ONE;
    // A write on the very first load cycle must measure against the cleared length.
    assign len_base = la_rise ? '0 : len_q;
    assign pos_inc  = pos_q + POS_ONE;

`ifdef CAS_RECORD_EN
    logic [2:0] sync_q;
    logic       cas_rise, armed_q, armed_d, rec_bit, rec_wr;
    logic [7:0] rec_byte;

    // sync_q[1] is the synchronised input, sync_q[2] its previous value.
    assign cas_rise = sync_q[1] && !sync_q[2];
    assign rec_bit  = (int'(cnt_q) + 1) < (HALF0 + HALF1);
    assign rec_byte = {rec_bit, shreg_q[7:1]};

    assign wr_en   = io_wr_ok || rec_wr;
    assign wr_addr = rec_wr ? pos_q[ADDR_W-1:0] : io.ioctl_addr[ADDR_W-1:0];
    assign wr_dat  = rec_wr ? rec_byte : io.ioctl_data;
`else
    assign wr_en   = io_wr_ok;
    assign wr_addr = io.ioctl_addr[ADDR_W-1:0];
    assign wr_dat  = io.ioctl_data;
`endif

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        rd_en   = 1'b0;
        len_d   = len_base;
`ifdef CAS_RECORD_EN
        armed_d = armed_q;
        rec_wr  = 1'b0;
`endif
        if (io_wr_ok && (io_end > len_base)) begin
            len_d = io_end;
        end

        if (la) begin
            state_d = ST_IDLE;
            if (la_rise) begin
                pos_d = '0;
            end
        end else if (rewind) begin
            state_d = ST_IDLE;
            pos_d   = '0;
        end else if (motor) begin
`ifdef CAS_RECORD_EN
            if (rec && (state_q != ST_EOT) && (state_q != ST_REC)) begin
                state_d = ST_REC;
                cnt_d   = '0;
                bit_d   = '0;
                armed_d = 1'b0;
            end else
`endif
            begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = (pos_q >= len_q) ? ST_EOT : ST_FETCH;
                    end
                    ST_FETCH: begin
                        rd_en   = 1'b1;
                        state_d = ST_WAIT;
                    end
                    ST_WAIT: begin
                        shreg_d = rd_dat;
                        bit_d   = '0;
                        cnt_d   = half_sel(rd_dat[0]);
                        state_d = ST_HIGH;
                    end
                    ST_HIGH: begin
                        if (cnt_q == '0) begin
                            cnt_d   = half_sel(shreg_q[0]);
                            state_d = ST_LOW;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_q == '0) begin
                            shreg_d = shreg_q >> 1;
                            bit_d   = bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                pos_d   = pos_inc;
                                state_d = ST_IDLE;
                            end else begin
                                // shreg_q[1] is the next bit once this shift lands.
                                cnt_d   = half_sel(shreg_q[1]);
                                state_d = ST_HIGH;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
`ifdef CAS_RECORD_EN
                    ST_REC: begin
                        if (!rec) begin
                            state_d = ST_IDLE;
                        end else if (cas_rise) begin
                            cnt_d   = '0;
                            armed_d = 1'b1;
                            if (armed_q) begin
                                shreg_d = rec_byte;
                                bit_d   = bit_q + 3'd1;
                                if (bit_q == 3'd7) begin
                                    if (pos_q[ADDR_W]) begin
                                        state_d = ST_EOT;
                                    end else begin
                                        rec_wr = 1'b1;
                                        pos_d  = pos_inc;
                                        if (pos_inc > len_q) begin
                                            len_d = pos_inc;
                                        end
                                        if (pos_inc[ADDR_W]) begin
                                            state_d = ST_EOT;
                                        end
                                    end
                                end
                            end
                        end else if (&cnt_q) begin
                            // Lost carrier: drop the partial byte and resync on the next edge.
                            armed_d = 1'b0;
                            bit_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
`endif
                    ST_EOT: begin
                        state_d = ST_EOT;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            la_q    <= 1'b0;
            pos_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            la_q    <= la;
            pos_q   <= pos_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end

`ifdef CAS_RECORD_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], cas_in};
            armed_q <= armed_d;
        end
    end
`endif

    cas_tape_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_en   (rd_en),
        .rd_addr (pos_q[ADDR_W-1:0]),
        .rd_dat  (rd_dat)
    );

    assign cas_out  = (state_q == ST_HIGH);
    assign eot      = (state_q == ST_EOT);
    assign playing  = motor && ((state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                                (state_q == ST_HIGH)  || (state_q == ST_LOW));
    assign position = pos_q[ADDR_W-1:0];
    assign length   = len_q;

endmodule

// File: tb/tb_cas_tape_engine.sv
// Bench for cas_tape_engine with short half-periods; cas_out runs checked against a segment scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_cas_tape_engine;

    localparam int AW = 4;
    localparam int CW = 8;
    localparam int H0 = 24;
    localparam int H1 = 12;
    localparam int LI = 12;

    typedef struct {
        bit lvl;
        int len;
    } seg_t;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          motor;
    logic          rewind;
`ifdef CAS_RECORD_EN
    logic          rec;
    logic          cas_in;
`endif
    logic          cas_out;
    logic          playing;
    logic          eot;
    logic [AW-1:0] position;
    logic [AW:0]   length;

    cas_tape_engine_if io ();

    always #5 clk_sys = ~clk_sys;

    cas_tape_engine #(
        .ADDR_W     (AW),
        .LOAD_INDEX (LI),
        .CNT_W      (CW),
        .HALF0      (H0),
        .HALF1      (H1)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .io       (io),
        .motor    (motor),
        .rewind   (rewind),
`ifdef CAS_RECORD_EN
        .rec      (rec),
        .cas_in   (cas_in),
`endif
        .cas_out  (cas_out),
        .playing  (playing),
        .eot      (eot),
        .position (position),
        .length   (length)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    seg_t sb_q[$];
    bit   sb_en = 1'b0;
    bit   armed = 1'b0;
    bit   prev  = 1'b0;
    int   run_len = 0;
    int   rise_cnt = 0;
    seg_t s;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Segment monitor: every completed cas_out run is popped and compared.
    always @(negedge clk_sys) begin
        if (!sb_en) begin
            armed = 1'b0;
        end else if (armed) begin
            if (cas_out !== prev) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_empty", sb_q.size(), 1);
                end else begin
                    s = sb_q.pop_front();
                    check_eq("seg_lvl", {31'd0, prev}, {31'd0, s.lvl});
                    check_eq("seg_len", run_len, s.len);
                end
                run_len = 1;
            end else begin
                run_len++;
            end
        end else if (cas_out === 1'b1 && prev == 1'b0) begin
            armed   = 1'b1;
            run_len = 1;
        end
        if (cas_out === 1'b1 && prev == 1'b0) rise_cnt++;
        prev = (cas_out === 1'b1);
    end

    task automatic push_byte(input logic [7:0] b, input int hi_extra);
        for (int i = 0; i < 8; i++) begin
            int h;
            h = b[i] ? H1 : H0;
            sb_q.push_back('{lvl: 1'b1, len: h + ((i == 0) ? hi_extra : 0)});
            sb_q.push_back('{lvl: 1'b0, len: h + ((i == 7) ? 3 : 0)});
        end
    endtask

    task automatic io_write(input int addr, input logic [7:0] dat);
        io.ioctl_addr = 25'(addr);
        io.ioctl_data = dat;
        io.ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        io.ioctl_wr   = 1'b0;
    endtask

    task automatic wait_eot(input int budget);
        int n;
        n = 0;
        while (eot !== 1'b1 && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("eot_reached", {31'd0, eot}, 1);
    endtask

    task automatic wait_rises(input int target, input int budget);
        int n;
        n = 0;
        while (rise_cnt < target && n < budget) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("rise_wait", (rise_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic rewind_pulse();
        rewind = 1'b1;
        @(negedge clk_sys);
        check_eq("rew_pos", position, 0);
        check_eq("rew_eot", {31'd0, eot}, 0);
        check_eq("rew_cas", {31'd0, cas_out}, 0);
        rewind = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected run completion");
        $fatal(1);
    end

    initial begin
        int base;
        reset_n           = 1'b0;
        motor             = 1'b1;
        rewind            = 1'b0;
        io.ioctl_download = 1'b0;
        io.ioctl_index    = 8'd0;
        io.ioctl_wr       = 1'b0;
        io.ioctl_addr     = '0;
        io.ioctl_data     = '0;
`ifdef CAS_RECORD_EN
        rec               = 1'b0;
        cas_in            = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);
        check_eq("rst_cas", {31'd0, cas_out}, 0);
        check_eq("rst_play", {31'd0, playing}, 0);
        check_eq("rst_eot", {31'd0, eot}, 0);
        check_eq("rst_pos", position, 0);
        check_eq("rst_len", length, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check_eq("empty_eot", {31'd0, eot}, 1);

        // Load 0x01, 0x00 with the motor stopped.
        motor             = 1'b0;
        io.ioctl_index    = 8'(LI);
        io.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check_eq("load_eot", {31'd0, eot}, 0);
        io_write(0, 8'h01);
        io_write(1, 8'h00);
        io.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_eq("load_len", length, 2);
        check_eq("load_pos", position, 0);

        // Play, freezing 10 cycles in the first HIGH half of byte 1.
        sb_q.delete();
        push_byte(8'h01, 0);
        push_byte(8'h00, 10);
        sb_en = 1'b1;
        base  = rise_cnt;
        motor = 1'b1;
        wait_rises(base + 9, 1000);
        repeat (4) @(negedge clk_sys);
        motor = 1'b0;
        repeat (5) @(negedge clk_sys);
        check_eq("frz_cas", {31'd0, cas_out}, 1);
        check_eq("frz_play", {31'd0, playing}, 0);
        check_eq("frz_pos", position, 1);
        repeat (5) @(negedge clk_sys);
        motor = 1'b1;
        @(negedge clk_sys);
        check_eq("run_play", {31'd0, playing}, 1);
        wait_eot(2000);
        check_eq("end_pos", position, 2);
        check_eq("sb_left", sb_q.size(), 1);
        sb_en = 1'b0;

        // Rewind mid-byte 1, then a clean replay from byte 0.
        @(negedge clk_sys);
        rewind_pulse();
        repeat (400) @(negedge clk_sys);
        check_eq("mid_pos", position, 1);
        sb_q.delete();
        push_byte(8'h01, 0);
        push_byte(8'h00, 0);
        rewind_pulse();
        sb_en = 1'b1;
        wait_eot(2000);
        check_eq("rp_pos", position, 2);
        check_eq("rp_left", sb_q.size(), 1);
        sb_en = 1'b0;

        // New download during playback, out-of-range writes, foreign index.
        @(negedge clk_sys);
        rewind_pulse();
        repeat (400) @(negedge clk_sys);
        check_eq("mid_pos2", position, 1);
        io.ioctl_index    = 8'(LI);
        io.ioctl_download = 1'b1;
        @(negedge clk_sys);
        check_eq("ld_pos", position, 0);
        check_eq("ld_len", length, 0);
        check_eq("ld_cas", {31'd0, cas_out}, 0);
        check_eq("ld_play", {31'd0, playing}, 0);
        io_write(16, 8'hFF);
        check_eq("oor_len0", length, 0);
        io_write(0, 8'h02);
        io_write(2, 8'h80);
        check_eq("len3", length, 3);
        io_write(1, 8'h00);
        check_eq("len_max", length, 3);
        io_write(16, 8'hFF);
        check_eq("oor_len", length, 3);
        sb_q.delete();
        push_byte(8'h02, 0);
        push_byte(8'h00, 0);
        push_byte(8'h80, 0);
        sb_en = 1'b1;
        io.ioctl_download = 1'b0;
        @(negedge clk_sys);
        io.ioctl_index    = 8'd5;
        io.ioctl_download = 1'b1;
        io_write(1, 8'hFF);
        io_write(9, 8'h33);
        io.ioctl_download = 1'b0;
        check_eq("idx_len", length, 3);
        wait_eot(3000);
        check_eq("p4_pos", position, 3);
        check_eq("p4_left", sb_q.size(), 1);
        sb_en = 1'b0;

`ifdef CAS_RECORD_EN
        // Record 0xA5 (LSB first), then play it back.
        motor             = 1'b0;
        io.ioctl_index    = 8'(LI);
        io.ioctl_download = 1'b1;
        @(negedge clk_sys);
        io.ioctl_download = 1'b0;
        @(negedge clk_sys);
        check_eq("rec_len0", length, 0);
        rec   = 1'b1;
        motor = 1'b1;
        repeat (4) @(negedge clk_sys);
        for (int k = 0; k < 9; k++) begin
            int p;
            p = (k == 8) ? 4 : ((((8'hA5 >> k) & 1) != 0) ? 2 * H1 : 2 * H0);
            cas_in = 1'b1;
            repeat (p / 2) @(negedge clk_sys);
            cas_in = 1'b0;
            repeat (p / 2) @(negedge clk_sys);
        end
        repeat (6) @(negedge clk_sys);
        rec = 1'b0;
        repeat (4) @(negedge clk_sys);
        check_eq("rec_pos", position, 1);
        check_eq("rec_len", length, 1);
        check_eq("rec_eot", {31'd0, eot}, 1);
        sb_q.delete();
        push_byte(8'hA5, 0);
        rewind_pulse();
        sb_en = 1'b1;
        wait_eot(2000);
        check_eq("rec_left", sb_q.size(), 1);
        sb_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
